free_list: RTL and testbench
============================

# free_list

Physical-register free list for the rename stage. Holds the physical registers not currently mapped; rename pops one per allocating instruction, and the ROB pushes back `preg_old` on each retirement. Each allocation records a head-pointer checkpoint under its ROB tag, so a mispredict restores every register allocated by instructions younger than the branch in one cycle.

## Interface
Parameters:
- NUM_PREG, 128, physical registers (7-bit tags).
- NUM_AREG, 32, architectural registers; p0..p31 start mapped.
- FL_DEPTH, NUM_PREG-NUM_AREG = 96, free-list entries.
- ROB_DEPTH, 16, ROB entries (5-bit tags, ROB index range 0..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-low.
- alloc_en  in  1  rename consumes `pd_out` this cycle.
- alloc_rob_tag  in  5  ROB tag (ROB `ptr`) of the allocating instruction.
- pd_out  out  7  next free physical register (mem[head]).
- alloc_ready  out  1  list non-empty; `pd_out` is valid.
- retire_valid  in  1  ROB `valid_retired`.
- retire_preg  in  7  ROB `preg_old`; returned to the list.
- mispredict  in  1  branch recovery pulse.
- mispredict_tag  in  5  ROB tag of the mispredicted branch.
- free_count  out  7  entries currently free (0..96).

## Operation
- Storage: mem[0..95] of 7-bit tags, organised as a circular buffer.
- Pointers: head and tail are each {lap, idx}, with idx in 0..95 and a 1-bit lap.
- Pointer increment: idx==95 wraps to 0 and toggles lap.
- free_count derivation:
  - If lap equal: tail.idx - head.idx.
  - If lap differs: 96 - head.idx + tail.idx.
  - Result is 96 when the idx values are equal and the laps differ.
- Allocate: when alloc_en && alloc_ready, the head increments and snap[alloc_rob_tag] <= head_next.
  - alloc_en while !alloc_ready is ignored; rename must stall.
- Free: when retire_valid && retire_preg != 0, mem[tail.idx] <= retire_preg and the tail increments.
  - retire_preg == 0 is never pushed.
- Mispredict: head <= snap[mispredict_tag]. This restores all registers allocated by instructions younger than the branch.
  - The tail is untouched.
  - alloc_en in the same cycle is ignored.
- Simultaneous alloc + free: both apply in the same cycle.
- Simultaneous mispredict + retire: the push applies, the head is restored, and free_count is derived from the new pointers.
- A free on a full list (count 96) is a protocol error; the push is dropped and an assertion fires.
- Reset (reset==0 at posedge):
  - mem[i] = 32+i.
  - head = {0,0}, tail = {1,0}, free_count = 96.
  - alloc_ready = 1, pd_out = 32.
  - snap[] = 0.
  - Reset asserted mid-operation discards all in-flight state.

## Timing
- pd_out and alloc_ready are combinational from registered head and count.
  - An allocation consumes the register at the posedge where alloc_en is high.
  - The next register appears the following cycle.
- A freed register is available to alloc one cycle after the posedge at which it is pushed; there is no same-cycle bypass.
- Mispredict recovery takes 1 cycle: the restored pd_out is visible the cycle after the mispredict pulse.
- free_count updates at the same posedge as the pointers.

## Structure
- Add to types_pkg:
  - PREG_W=7, ROB_TAG_W=5.
  - NUM_PREG, NUM_AREG, FL_DEPTH, ROB_DEPTH.
  - typedef fl_ptr_t (struct {lap, idx[6:0]}).
- One sub-module, fl_ckpt_table: 16×8-bit snapshot RAM with one write port (alloc) and one async read port (mispredict).
- Pointer and count logic stay in free_list.

## Test plan
- Reset then 3 allocs at ROB tags 0,1,2 -> pd_out sequence 32,33,34; free_count 96→93.
- 96 back-to-back allocs -> alloc_ready=0, free_count=0. Further alloc_en is ignored with the head unchanged. Retire preg 5 -> the next cycle alloc_ready=1 and pd_out=5.
- Alloc p32@tag3, p33@tag4, p34@tag5, then mispredict_tag=3 -> the next cycle pd_out=33 and free_count restored by 2.
- Same-cycle alloc_en + retire_valid(preg 10) at count 50 -> count stays 50; p10 is written at the old tail.
- Mispredict + retire(preg 7) in the same cycle -> the head is restored, p7 is pushed, and free_count = restored value + 1.
- Wrap-around: 200 alternating alloc/free cycles -> lap bits toggle and free_count stays consistent; retire_preg=0 never changes the count.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizes, pointer type and pointer helpers for the rename-stage free list.
package free_list_pkg;
    localparam int PREG_W    = 7;
    localparam int ROB_TAG_W = 5;
    localparam int NUM_PREG  = 128;
    localparam int NUM_AREG  = 32;
    localparam int FL_DEPTH  = NUM_PREG - NUM_AREG;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 7;
    localparam int CKPT_AW   = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic             lap;
        logic [IDX_W-1:0] idx;
    } fl_ptr_t;

    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        fl_ptr_t r;
        r = p;
        if (p.idx == IDX_W'(FL_DEPTH - 1)) begin
            r.idx = '0;
            r.lap = ~p.lap;
        end else begin
            r.idx = p.idx + IDX_W'(1);
        end
        return r;
    endfunction

    // Differing laps mean the tail has wrapped past the head; 7-bit modular math
    // is exact because the true count never exceeds FL_DEPTH.
    function automatic logic [PREG_W-1:0] ptr_count(input fl_ptr_t h, input fl_ptr_t t);
        if (h.lap == t.lap)
            return t.idx - h.idx;
        else
            return PREG_W'(FL_DEPTH) - h.idx + t.idx;
    endfunction
endpackage

// File: rtl/free_list_if.sv
// Rename/retire/recovery signals of the free list; master drives requests, slave is the list.
interface free_list_if;
    import free_list_pkg::*;

    logic                 alloc_en;
    logic [ROB_TAG_W-1:0] alloc_rob_tag;
    logic [PREG_W-1:0]    pd_out;
    logic                 alloc_ready;
    logic                 retire_valid;
    logic [PREG_W-1:0]    retire_preg;
    logic                 mispredict;
    logic [ROB_TAG_W-1:0] mispredict_tag;
    logic [PREG_W-1:0]    free_count;

    modport master (
        output alloc_en, alloc_rob_tag, retire_valid, retire_preg, mispredict, mispredict_tag,
        input  pd_out, alloc_ready, free_count
    );

    modport slave (
        input  alloc_en, alloc_rob_tag, retire_valid, retire_preg, mispredict, mispredict_tag,
        output pd_out, alloc_ready, free_count
    );
endinterface

// File: rtl/fl_ckpt_table.sv
// Head-pointer checkpoints indexed by ROB entry: written on allocation, read
// combinationally on a mispredict.
module fl_ckpt_table
    import free_list_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [CKPT_AW-1:0] waddr,
    input  fl_ptr_t            wdata,
    input  logic [CKPT_AW-1:0] raddr,
    output fl_ptr_t            rdata
);
    fl_ptr_t              snap_reg [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_sel
            assign wr_sel[gi] = we && (waddr == CKPT_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (!reset)
                snap_reg[i] <= '0;
            else if (wr_sel[i])
                snap_reg[i] <= wdata;
        end
    end

    assign rdata = snap_reg[raddr];
endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free tags with lap-tagged
// head/tail pointers and single-cycle head restore on branch mispredict.
module free_list
    import free_list_pkg::*;
(
    input  logic clk,
    input  logic reset,
    free_list_if.slave fl
);
    logic [PREG_W-1:0] mem_reg [FL_DEPTH];
    fl_ptr_t           head_reg, head_next, head_inc;
    fl_ptr_t           tail_reg, tail_next;
    fl_ptr_t           snap_rdata;
    logic [PREG_W-1:0] count;
    logic              full;
    logic              do_alloc;
    logic              do_push;
    logic              unused_tag_msb;

    assign count    = ptr_count(head_reg, tail_reg);
    assign full     = (count == PREG_W'(FL_DEPTH));
    assign head_inc = ptr_inc(head_reg);

    // Recovery owns the head this cycle, so a concurrent allocation is dropped.
    assign do_alloc = fl.alloc_en && fl.alloc_ready && !fl.mispredict;
    assign do_push  = fl.retire_valid && (fl.retire_preg != '0) && !full;

    assign fl.alloc_ready = (count != '0);
    assign fl.pd_out      = mem_reg[head_reg.idx];
    assign fl.free_count  = count;

    // Only the ROB index bits select a checkpoint; the tag MSB is the ROB wrap bit.
    assign unused_tag_msb = fl.alloc_rob_tag[ROB_TAG_W-1] ^ fl.mispredict_tag[ROB_TAG_W-1];

    fl_ckpt_table u_ckpt (
        .clk   (clk),
        .reset (reset),
        .we    (do_alloc),
        .waddr (fl.alloc_rob_tag[CKPT_AW-1:0]),
        .wdata (head_inc),
        .raddr (fl.mispredict_tag[CKPT_AW-1:0]),
        .rdata (snap_rdata)
    );

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (fl.mispredict)
            head_next = snap_rdata;
        else if (do_alloc)
            head_next = head_inc;
        if (do_push)
            tail_next = ptr_inc(tail_reg);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_reg <= '0;
            tail_reg <= '{lap: 1'b1, idx: '0};
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                mem_reg[i] <= PREG_W'(NUM_AREG + i);
        end else if (do_push) begin
            mem_reg[tail_reg.idx] <= fl.retire_preg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && fl.retire_valid && (fl.retire_preg != '0))
            assert (!full);
    end
endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: directed scenarios plus randomized traffic
// checked against an unbounded-counter model of the free list.
module tb_free_list;
    import free_list_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    free_list_if fl ();

    free_list dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl)
    );

    typedef struct {
        bit    ready;
        int    pd;
        int    cnt;
        string lbl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: head/tail are total allocations/pushes since reset; slot = n % 96.
    int m_head, m_tail;
    int m_mem [FL_DEPTH];
    int m_snap[ROB_DEPTH];

    function automatic void model_reset();
        m_head = 0;
        m_tail = FL_DEPTH;
        for (int i = 0; i < FL_DEPTH; i++) m_mem[i] = NUM_AREG + i;
        for (int i = 0; i < ROB_DEPTH; i++) m_snap[i] = 0;
    endfunction

    function automatic int m_count();
        return m_tail - m_head;
    endfunction

    task automatic step(input bit rst_n, input bit a, input int atag, input bit r, input int rp,
                        input bit m, input int mt, input string lbl);
        int  cnt;
        bit  push;
        reset             = rst_n;
        fl.alloc_en       = a;
        fl.alloc_rob_tag  = ROB_TAG_W'(atag);
        fl.retire_valid   = r;
        fl.retire_preg    = PREG_W'(rp);
        fl.mispredict     = m;
        fl.mispredict_tag = ROB_TAG_W'(mt);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            cnt  = m_count();
            push = r && (rp != 0) && (cnt < FL_DEPTH);
            if (m) begin
                m_head = m_snap[mt];
            end else if (a && cnt > 0) begin
                m_head++;
                m_snap[atag] = m_head;
            end
            if (push) begin
                m_mem[m_tail % FL_DEPTH] = rp;
                m_tail++;
            end
        end
        exp_q.push_back('{m_count() != 0, m_mem[m_head % FL_DEPTH], m_count(), lbl});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 0, 0, "reset");
    endtask

    task automatic check(input string lbl, input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, required %0d", lbl, nm, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.lbl, "alloc_ready", int'(fl.alloc_ready), int'(e.ready));
                check(e.lbl, "free_count", int'(fl.free_count), e.cnt);
                if (e.ready) check(e.lbl, "pd_out", int'(fl.pd_out), e.pd);
            end
        end
    end

    initial begin
        int  cnt, rp, mt, d, bias;
        bit  a, r, m;

        // three allocations after reset: 32,33,34 consumed, count 96 -> 93
        do_reset();
        for (int t = 0; t < 3; t++) step(1, 1, t, 0, 0, 0, 0, "alloc3");

        // drain to empty, ignored allocs, then a retired p5 becomes next
        do_reset();
        for (int i = 0; i < FL_DEPTH; i++) step(1, 1, i % 16, 0, 0, 0, 0, "drain");
        for (int i = 0; i < 3; i++) step(1, 1, 9, 0, 0, 0, 0, "empty_alloc");
        step(1, 0, 0, 1, 5, 0, 0, "retire5");
        step(1, 1, 0, 0, 0, 0, 0, "alloc_p5");

        // checkpoint restore: allocs at tags 3,4,5 then mispredict tag 3
        do_reset();
        for (int t = 3; t <= 5; t++) step(1, 1, t, 0, 0, 0, 0, "ckpt_alloc");
        step(1, 0, 0, 0, 0, 1, 3, "mispredict3");
        idle(1);

        // simultaneous alloc + retire at count 50, then mispredict + retire
        do_reset();
        for (int i = 0; i < 46; i++) step(1, 1, i % 16, 0, 0, 0, 0, "to50");
        step(1, 1, 7, 1, 10, 0, 0, "alloc_retire");
        step(1, 0, 0, 1, 7, 1, 2, "mp_retire");
        step(1, 1, 1, 1, 0, 0, 0, "retire_zero");
        idle(2);

        // alternating alloc/free crossing lap boundaries; some zero retirements
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (i % 2 == 0) begin
                step(1, 1, i % 16, 0, 0, 0, 0, "alt_alloc");
            end else begin
                rp = (i % 20 == 1) ? 0 : int'($urandom_range(1, 127));
                step(1, 0, 0, m_count() < FL_DEPTH, rp, 0, 0, "alt_free");
            end
        end

        // randomized mix with occasional mispredicts to valid checkpoints
        for (int j = 0; j < 1500; j++) begin
            bias = ((j / 300) % 2 == 0) ? 3 : 1;
            a    = ($urandom_range(0, 3) < bias);
            cnt  = m_count();
            r    = (cnt < FL_DEPTH) && ($urandom_range(0, 3) >= bias);
            rp   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127));
            m    = 1'b0;
            mt   = int'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) begin
                d = m_tail + ((r && rp != 0) ? 1 : 0) - m_snap[mt];
                m = (d >= 0) && (d <= FL_DEPTH);
            end
            step(1, a, int'($urandom_range(0, 15)), r, rp, m, mt, "random");
        end

        // reset in the middle of traffic discards everything
        for (int i = 0; i < 5; i++) step(1, 1, i, 0, 0, 0, 0, "pre_reset");
        step(0, 1, 0, 1, 9, 0, 0, "mid_reset");
        for (int i = 0; i < 3; i++) step(1, 1, i, 0, 0, 0, 0, "post_reset");

        repeat (3) @(negedge clk);
        check("end", "pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
